// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: shared state encoding, frame opcodes and state-class helpers
// for the register-access command controller.
package reg_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_SEND
    } state_t;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;
    localparam logic [7:0] WR_ACK = 8'hA5;

    // States that are waiting for the next byte of a frame (frame timer runs).
    function automatic logic in_frame(state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
    endfunction

    // States in which an incoming RX byte cannot be accepted.
    function automatic logic in_exec(state_t s);
        return (s == WR_EXEC) || (s == RD_EXEC) || (s == RD_WAIT) || (s == TX_SEND);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter with clear and enable. o_Expire is
// high in the LOAD_VAL-th enabled cycle after a load.
module frame_timer #(
    parameter int LOAD_VAL = 1024
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_Clr,
    input  logic i_Load,
    input  logic i_En,
    output logic o_Expire
);

    localparam int CW = $clog2(LOAD_VAL + 1);

    logic [CW-1:0] cnt;

    // Clear has priority over load; counting stops at zero.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            cnt <= '0;
        end else if (i_Clr) begin
            cnt <= '0;
        end else if (i_Load) begin
            cnt <= CW'(LOAD_VAL);
        end else if (i_En && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_Expire = i_En && (cnt == CW'(1));

endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: parses AA/addr/data write frames and BB/addr read frames from
// the UART RX path, strobes the register file, and returns read data on TX.
// Optional feature macro REG_CMD_WR_ACK_EN: every completed write is answered
// with an 8'hA5 acknowledge byte on TX.
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FRAME_TIMEOUT = 1024,
    parameter int RD_TIMEOUT    = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [DATA_WIDTH-1:0] i_RX_Data,
    input  logic                  i_RX_Valid,
    output logic                  o_WrEn,
    output logic                  o_RdEn,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_WrData,
    input  logic [DATA_WIDTH-1:0] i_RdData,
    input  logic                  i_RdData_Valid,
    output logic [DATA_WIDTH-1:0] o_TX_Data,
    output logic                  o_TX_Valid,
    input  logic                  i_TX_Busy,
    output logic                  o_Frame_Err
);

    state_t state;
    logic   frm_expire;
    logic   rd_expire;
    logic   addr_bad;

    assign addr_bad = |i_RX_Data[DATA_WIDTH-1:ADDR_WIDTH];

    // Inter-byte timer: every RX byte reloads it, it only counts while a
    // frame is partially received and is held cleared otherwise.
    frame_timer #(.LOAD_VAL(FRAME_TIMEOUT)) u_frm_timer (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_Clr    (!in_frame(state) && !i_RX_Valid),
        .i_Load   (i_RX_Valid),
        .i_En     (in_frame(state) && !i_RX_Valid),
        .o_Expire (frm_expire)
    );

    // Read-response timer: loaded while the read strobe is out, counts in RD_WAIT.
    frame_timer #(.LOAD_VAL(RD_TIMEOUT)) u_rd_timer (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_Clr    ((state != RD_EXEC) && (state != RD_WAIT)),
        .i_Load   (state == RD_EXEC),
        .i_En     ((state == RD_WAIT) && !i_RdData_Valid),
        .o_Expire (rd_expire)
    );

    // Frame parser and access sequencer; strobes and error are one-cycle pulses.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state       <= IDLE;
            o_WrEn      <= 1'b0;
            o_RdEn      <= 1'b0;
            o_Address   <= '0;
            o_WrData    <= '0;
            o_TX_Data   <= '0;
            o_TX_Valid  <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_WrEn      <= 1'b0;
            o_RdEn      <= 1'b0;
            o_TX_Valid  <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_RX_Valid) begin
                        if (i_RX_Data == DATA_WIDTH'(WR_CMD)) begin
                            state <= WR_ADDR;
                        end else if (i_RX_Data == DATA_WIDTH'(RD_CMD)) begin
                            state <= RD_ADDR;
                        end else begin
                            o_Frame_Err <= 1'b1;
                        end
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if (i_RX_Valid) begin
                        if (addr_bad) begin
                            o_Frame_Err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            o_Address <= i_RX_Data[ADDR_WIDTH-1:0];
                            if (state == WR_ADDR) begin
                                state <= WR_DATA;
                            end else begin
                                o_RdEn <= 1'b1;
                                state  <= RD_EXEC;
                            end
                        end
                    end else if (frm_expire) begin
                        o_Frame_Err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (i_RX_Valid) begin
                        o_WrData <= i_RX_Data;
                        o_WrEn   <= 1'b1;
                        state    <= WR_EXEC;
                    end else if (frm_expire) begin
                        o_Frame_Err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WR_EXEC: begin
`ifdef REG_CMD_WR_ACK_EN
                    // Ack goes out next cycle already if TX is free.
                    o_TX_Data  <= DATA_WIDTH'(WR_ACK);
                    o_TX_Valid <= !i_TX_Busy;
                    state      <= TX_SEND;
`else
                    state <= IDLE;
`endif
                end
                RD_EXEC: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (i_RdData_Valid) begin
                        // Request TX in the same edge so an idle TX sees it next cycle.
                        o_TX_Data  <= i_RdData;
                        o_TX_Valid <= !i_TX_Busy;
                        state      <= TX_SEND;
                    end else if (rd_expire) begin
                        o_Frame_Err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                TX_SEND: begin
                    if (o_TX_Valid) begin
                        state <= IDLE;
                    end else if (!i_TX_Busy) begin
                        o_TX_Valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Bytes arriving while an access is in flight are dropped.
            if (i_RX_Valid && in_exec(state)) begin
                o_Frame_Err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Register-access command controller: the initiator side of the register file's read/write port. Parses byte frames from the UART receive path (write frame: command, address, data; read frame: command, address). It issues single-cycle write/read strobes to the register file, captures the registered read response, and hands the read byte to the UART transmit path. It sits between UART RX/TX and the register file in the system-control domain.

## Interface
- DATA_WIDTH, 8, width of RX/TX bytes and register data
- ADDR_WIDTH, 4, register file address width (ADDR_WIDTH < DATA_WIDTH)
- FRAME_TIMEOUT, 1024, max cycles allowed between bytes of one frame
- RD_TIMEOUT, 4, max cycles from o_RdEn to i_RdData_Valid
- i_CLK  in  1  system clock
- i_RST  in  1  reset; synchronous, active-low
- i_RX_Data  in  DATA_WIDTH  received byte
- i_RX_Valid  in  1  single-cycle pulse per received byte
- o_WrEn  out  1  register write strobe
- o_RdEn  out  1  register read strobe
- o_Address  out  ADDR_WIDTH  register address
- o_WrData  out  DATA_WIDTH  register write data
- i_RdData  in  DATA_WIDTH  register read data
- i_RdData_Valid  in  1  read data valid pulse
- o_TX_Data  out  DATA_WIDTH  byte to transmitter
- o_TX_Valid  out  1  single-cycle transmit request
- i_TX_Busy  in  1  transmitter busy
- o_Frame_Err  out  1  single-cycle pulse on any frame/protocol error

## Operation
- All outputs registered. Reset value of every output is 0. Reset clears state to IDLE, counters to 0.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE, byte 8'hAA goes to WR_ADDR. Byte 8'hBB goes to RD_ADDR. Any other byte pulses o_Frame_Err and stays in IDLE.
- WR_ADDR / RD_ADDR, on a byte:
  - If bits [DATA_WIDTH-1:ADDR_WIDTH] are nonzero: o_Frame_Err, return to IDLE, no access.
  - Otherwise latch o_Address. WR_ADDR goes to WR_DATA; RD_ADDR goes to RD_EXEC.
- WR_DATA: on a byte, latch o_WrData and go to WR_EXEC.
- WR_EXEC: o_WrEn=1 for exactly one cycle, then IDLE.
- RD_EXEC: o_RdEn=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT: on i_RdData_Valid, latch i_RdData into o_TX_Data and go to TX_SEND. If RD_TIMEOUT cycles pass without it: o_Frame_Err, IDLE.
- TX_SEND: when i_TX_Busy=0, pulse o_TX_Valid one cycle, then IDLE. While busy, wait indefinitely with o_TX_Data held stable.
- Frame timeout: in WR_ADDR, WR_DATA or RD_ADDR, FRAME_TIMEOUT consecutive cycles without i_RX_Valid cause o_Frame_Err and IDLE. The counter clears on every accepted byte.
- An i_RX_Valid arriving in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: byte dropped, o_Frame_Err pulsed, state unaffected.
- o_WrEn and o_RdEn are never high together. o_Address and o_WrData hold their last values between accesses.
- i_RdData_Valid outside RD_WAIT is ignored.

## Timing
- Write: data byte valid at cycle N gives o_WrEn high at N+1.
- Read: address byte at N gives o_RdEn at N+1. With register-file read latency of 1, i_RdData_Valid arrives at N+2 and o_TX_Valid at N+3 if the transmitter is idle.
- Earliest next frame command byte is accepted in the cycle after return to IDLE.
- o_Frame_Err is asserted the cycle after the offending event.
- Reset mid-frame: the next active clock edge with i_RST=0 forces IDLE and drops all strobes. No partial write is issued.

## Configuration
- REG_CMD_WR_ACK_EN:
  - Defined: WR_EXEC goes to TX_SEND with o_TX_Data=8'hA5, so every completed write is acknowledged on TX under the same busy handshake.
  - Undefined: WR_EXEC returns directly to IDLE and writes produce no TX traffic.

## Structure
- Package reg_cmd_pkg: state enum, opcodes WR_CMD=8'hAA and RD_CMD=8'hBB, WR_ACK=8'hA5.
- One sub-module, frame_timer: a loadable down-counter with clear/enable and an expiry pulse, instantiated for both FRAME_TIMEOUT and RD_TIMEOUT.

## Test plan
- AA, 05, 3C bytes -> one-cycle o_WrEn with o_Address=5, o_WrData=8'h3C. Ack 8'hA5 on TX only with REG_CMD_WR_ACK_EN.
- BB, 02 with responder returning 8'h81 one cycle after o_RdEn -> o_TX_Valid pulse with o_TX_Data=8'h81, total latency 3 cycles from the address byte.
- Same read with i_TX_Busy held high for 20 cycles -> o_TX_Valid fires the first cycle after busy drops, data stable throughout.
- Byte 8'h77 in IDLE; AA, 8'h15 (upper bits set) -> o_Frame_Err pulse each time, no o_WrEn or o_RdEn.
- AA, 03, then silence for FRAME_TIMEOUT cycles -> o_Frame_Err, IDLE. A subsequent BB, 03 read completes normally.
- Assert i_RST low in WR_DATA, then release and send the data byte -> no o_WrEn, and all outputs are 0 after reset.
